pc_next_controller: RTL

- Drives the write side of the program counter: computes the next fetch address and its write strobe every cycle.
- Selects among sequential increment, branch and jump redirects, with hazard-stall holding and post-reset settling.
- Sits in the IF stage between the hazard/branch-resolution logic and the PC register.
- Its Address/WriteEnable feed the PC register's Address/WriteEnable inputs; the PC register's current value returns on PC.

---
 rtl/pc_next_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pc_next_controller.sv
// pc_next_controller
//   IF-stage next-PC selection. Every cycle it produces the address to load
//   into the PC register and the matching write strobe. The address is one of:
//   the sequential step, a branch or jump redirect, or a redirect that was
//   parked while a hazard stall was active.
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous, active-high
//   PC           current PC register value
//   Stall        load-use hazard stall (level); blocks the PC update
//   BranchTaken  branch resolved taken (pulse); wins over Jump
//   BranchTarget branch target byte address
//   Jump         jump / jr resolved (pulse)
//   JumpTarget   jump target byte address
//   Address      next PC value (combinational)
//   WriteEnable  PC load strobe
//   Flush        squash IF/ID; high in the cycle a redirect is applied
//   Wrap         selected address exceeded MAX_ADDR and was forced to 0
//   Misalign     applied target had nonzero bits[1:0]
//   Overrun      redirect arrived while one was already pending (dropped)
module pc_next_controller #(
  parameter int MAX_ADDR   = 228,
  parameter int INCREMENT  = 4,
  parameter int RESET_HOLD = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] Address,
  output logic        WriteEnable,
  output logic        Flush,
  output logic        Wrap,
  output logic        Misalign,
  output logic        Overrun
);

  localparam logic [31:0] MAX_A    = 32'(MAX_ADDR);
  localparam logic [31:0] INC      = 32'(INCREMENT);
  localparam logic [3:0]  HOLD_CNT = 4'(RESET_HOLD);

  typedef enum logic [1:0] {HOLD, RUN, STALL, PEND} state_t;

  state_t      state, state_nx;
  logic [31:0] pending, pending_nx;  // raw target; low bits kept for Misalign
  logic [3:0]  cnt, cnt_nx;

  logic        redirect;
  logic [31:0] raw_tgt, seq_addr;

  assign redirect = BranchTaken | Jump;
  assign raw_tgt  = BranchTaken ? BranchTarget : JumpTarget;
  assign seq_addr = PC + INC;

  // state register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= HOLD;
      cnt     <= HOLD_CNT;
      pending <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pending <= pending_nx;
    end
  end

  // next state
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pending_nx = pending;
    case (state)
      HOLD: begin
        cnt_nx = cnt - 4'd1;
        if (cnt <= 4'd1) state_nx = RUN;
      end
      RUN, STALL: begin
        if (Stall) begin
          if (redirect) begin
            pending_nx = raw_tgt;
            state_nx   = PEND;
          end else begin
            state_nx = STALL;
          end
        end else begin
          state_nx = RUN;
        end
      end
      PEND: begin
        // first parked redirect wins; later ones only raise Overrun
        if (!Stall) state_nx = RUN;
      end
      default: state_nx = HOLD;
    endcase
  end

  // outputs
  logic [31:0] addr_sel;
  always_comb begin
    addr_sel    = '0;
    WriteEnable = 1'b0;
    Flush       = 1'b0;
    Misalign    = 1'b0;
    Overrun     = 1'b0;
    Wrap        = 1'b0;
    Address     = '0;
    case (state)
      RUN, STALL: begin
        if (!Stall) begin
          WriteEnable = 1'b1;
          if (redirect) begin
            addr_sel = {raw_tgt[31:2], 2'b00};
            Flush    = 1'b1;
            Misalign = |raw_tgt[1:0];
          end else begin
            addr_sel = seq_addr;
          end
        end else begin
          addr_sel = PC;
        end
      end
      PEND: begin
        Overrun = redirect;
        if (!Stall) begin
          WriteEnable = 1'b1;
          Flush       = 1'b1;
          addr_sel    = {pending[31:2], 2'b00};
          Misalign    = |pending[1:0];
        end else begin
          addr_sel = PC;
        end
      end
      default: ;
    endcase
    // out-of-range writes fold back to address 0
    Wrap    = WriteEnable && (addr_sel > MAX_A);
    Address = Wrap ? '0 : addr_sel;
    if (Reset) begin
      Address     = '0;
      WriteEnable = 1'b0;
      Flush       = 1'b0;
      Wrap        = 1'b0;
      Misalign    = 1'b0;
      Overrun     = 1'b0;
    end
  end

endmodule
